// File: rtl/packed_lane_gearbox.sv
// Width-down gearbox: accepts one IN_LANES-lane word and replays it as a sequence of
// OUT_LANES-lane beats in ascending order, descending order, or as replicated single lanes.
module packed_lane_gearbox #(
  parameter int LANE_W    = 8,
  parameter int IN_LANES  = 4,
  parameter int OUT_LANES = 2,
  localparam int BEAT_W   = (IN_LANES > 1) ? $clog2(IN_LANES) : 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [0:IN_LANES-1][0:LANE_W-1]     in_data,
  input  logic [1:0]                          in_mode,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic [0:OUT_LANES-1][0:LANE_W-1]    out_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                out_last,
  output logic [BEAT_W-1:0]                   out_beat,
  output logic                                err_mode
);

  localparam int NB_SPLIT = IN_LANES / OUT_LANES;
  localparam logic [BEAT_W-1:0] SPLIT_LAST = BEAT_W'(NB_SPLIT - 1);
  localparam logic [BEAT_W-1:0] REP_LAST   = BEAT_W'(IN_LANES - 1);

  typedef enum logic {IDLE, SEND} state_e;
  typedef enum logic [1:0] {
    MODE_ASC  = 2'b00,
    MODE_DESC = 2'b01,
    MODE_REP  = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  state_e                          state, next_state;
  mode_e                           mode_q;
  logic [0:IN_LANES-1][0:LANE_W-1] hold;
  logic [BEAT_W-1:0]               counter;
  logic [BEAT_W-1:0]               last_idx;
  logic [BEAT_W-1:0]               base;
  logic                            accept;
  logic                            beat_xfer;

  assign accept    = in_valid & in_ready;
  assign beat_xfer = out_valid & out_ready;
  assign last_idx  = (mode_q == MODE_REP) ? REP_LAST : SPLIT_LAST;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (in_valid) next_state = SEND;
      SEND: if (beat_xfer && out_last && !in_valid) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // in_ready looks through out_ready on the last beat so consecutive words abut without a bubble.
  always_comb begin
    out_valid = (state == SEND);
    out_last  = (state == SEND) && (counter == last_idx);
    in_ready  = !rst && ((state == IDLE) || ((state == SEND) && out_ready && out_last));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold     <= '0;
      mode_q   <= MODE_ASC;
      counter  <= '0;
      err_mode <= 1'b0;
    end else begin
      err_mode <= accept && (in_mode == 2'b11);
      if (accept) begin
        hold    <= in_data;
        mode_q  <= mode_e'(in_mode);
        counter <= '0;
      end else if (beat_xfer) begin
        counter <= out_last ? '0 : counter + 1'b1;
      end
    end
  end

  always_comb begin
    if (mode_q == MODE_DESC) base = BEAT_W'((NB_SPLIT - 1 - int'(counter)) * OUT_LANES);
    else                     base = BEAT_W'(int'(counter) * OUT_LANES);
  end

  for (genvar j = 0; j < OUT_LANES; j++) begin : g_lane
    localparam logic [BEAT_W-1:0] OFF = BEAT_W'(j);
    assign out_data[j] = (mode_q == MODE_REP) ? hold[counter] : hold[base + OFF];
  end

  assign out_beat = counter;

endmodule

// File: tb/tb_packed_lane_gearbox.sv
// Directed bench for packed_lane_gearbox: default 4->2 lane instance plus a 4->4 degenerate instance.
module tb_packed_lane_gearbox;

  logic clk = 1'b0;
  logic rst;

  logic [0:3][0:7] in_data;
  logic [1:0]      in_mode;
  logic            in_valid;
  logic            in_ready;
  logic [0:1][0:7] out_data;
  logic            out_valid;
  logic            out_ready;
  logic            out_last;
  logic [1:0]      out_beat;
  logic            err_mode;

  logic [0:3][0:7] d_in_data;
  logic [1:0]      d_in_mode;
  logic            d_in_valid;
  logic            d_in_ready;
  logic [0:3][0:7] d_out_data;
  logic            d_out_valid;
  logic            d_out_ready;
  logic            d_out_last;
  logic [1:0]      d_out_beat;
  logic            d_err_mode;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  packed_lane_gearbox #(.LANE_W(8), .IN_LANES(4), .OUT_LANES(2)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_mode(in_mode), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_beat(out_beat), .err_mode(err_mode)
  );

  packed_lane_gearbox #(.LANE_W(8), .IN_LANES(4), .OUT_LANES(4)) dut_deg (
    .clk(clk), .rst(rst),
    .in_data(d_in_data), .in_mode(d_in_mode), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .out_data(d_out_data), .out_valid(d_out_valid), .out_ready(d_out_ready),
    .out_last(d_out_last), .out_beat(d_out_beat), .err_mode(d_err_mode)
  );

  // Inputs change 1ns after the rising edge; outputs are sampled 1ns later, mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic [1:0] m, input logic r);
    in_valid  = v;
    in_data   = d;
    in_mode   = m;
    out_ready = r;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expectBeat(input string tag, input logic v, input logic [15:0] d,
                            input logic [1:0] b, input logic l, input logic rdy);
    checkOutput({tag, ".valid"}, 32'(out_valid), 32'(v));
    checkOutput({tag, ".ready"}, 32'(in_ready), 32'(rdy));
    if (v) begin
      checkOutput({tag, ".data"}, 32'(out_data), 32'(d));
      checkOutput({tag, ".beat"}, 32'(out_beat), 32'(b));
      checkOutput({tag, ".last"}, 32'(out_last), 32'(l));
    end else begin
      checkOutput({tag, ".last"}, 32'(out_last), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    d_in_data = '0; d_in_mode = 2'b00; d_in_valid = 1'b0; d_out_ready = 1'b1;
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b1);
    tick();
    tick();

    // Reset state
    checkOutput("rst.valid", 32'(out_valid), 32'd0);
    checkOutput("rst.ready", 32'(in_ready), 32'd0);
    checkOutput("rst.data",  32'(out_data), 32'd0);
    checkOutput("rst.beat",  32'(out_beat), 32'd0);
    checkOutput("rst.last",  32'(out_last), 32'd0);
    checkOutput("rst.err",   32'(err_mode), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("idle.ready", 32'(in_ready), 32'd1);

    // Ascending split
    applyStimulus(1'b1, 32'h11223344, 2'b00, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b1);
    expectBeat("asc.b0", 1'b1, 16'h1122, 2'd0, 1'b0, 1'b0);
    tick();
    expectBeat("asc.b1", 1'b1, 16'h3344, 2'd1, 1'b1, 1'b1);
    tick();
    expectBeat("asc.idle", 1'b0, 16'h0, 2'd0, 1'b0, 1'b1);

    // Descending split
    applyStimulus(1'b1, 32'hA1B2C3D4, 2'b01, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b1);
    expectBeat("desc.b0", 1'b1, 16'hC3D4, 2'd0, 1'b0, 1'b0);
    checkOutput("desc.err", 32'(err_mode), 32'd0);
    tick();
    expectBeat("desc.b1", 1'b1, 16'hA1B2, 2'd1, 1'b1, 1'b1);
    tick();

    // Reserved mode: ascending order plus a single err_mode pulse
    applyStimulus(1'b1, 32'hA1B2C3D4, 2'b11, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b1);
    expectBeat("rsvd.b0", 1'b1, 16'hA1B2, 2'd0, 1'b0, 1'b0);
    checkOutput("rsvd.err0", 32'(err_mode), 32'd1);
    tick();
    expectBeat("rsvd.b1", 1'b1, 16'hC3D4, 2'd1, 1'b1, 1'b1);
    checkOutput("rsvd.err1", 32'(err_mode), 32'd0);
    tick();
    checkOutput("rsvd.err2", 32'(err_mode), 32'd0);

    // Replicate
    applyStimulus(1'b1, 32'h11223344, 2'b10, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b1);
    expectBeat("rep.b0", 1'b1, 16'h1111, 2'd0, 1'b0, 1'b0);
    tick();
    expectBeat("rep.b1", 1'b1, 16'h2222, 2'd1, 1'b0, 1'b0);
    tick();
    expectBeat("rep.b2", 1'b1, 16'h3333, 2'd2, 1'b0, 1'b0);
    tick();
    expectBeat("rep.b3", 1'b1, 16'h4444, 2'd3, 1'b1, 1'b1);
    tick();
    expectBeat("rep.idle", 1'b0, 16'h0, 2'd0, 1'b0, 1'b1);

    // Backpressure: out_ready 1,0,0,1 across the beats of an ascending word
    applyStimulus(1'b1, 32'h55667788, 2'b00, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b1);
    expectBeat("bp.b0", 1'b1, 16'h5566, 2'd0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b0);
    expectBeat("bp.stall1", 1'b1, 16'h7788, 2'd1, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b0);
    expectBeat("bp.stall2", 1'b1, 16'h7788, 2'd1, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b1);
    expectBeat("bp.b1", 1'b1, 16'h7788, 2'd1, 1'b1, 1'b1);
    tick();
    expectBeat("bp.idle", 1'b0, 16'h0, 2'd0, 1'b0, 1'b1);

    // Back-to-back words; in_mode wiggles during SEND without effect on the held word
    applyStimulus(1'b1, 32'h01020304, 2'b00, 1'b1);
    tick();
    applyStimulus(1'b1, 32'h05060708, 2'b01, 1'b1);
    expectBeat("b2b.w0b0", 1'b1, 16'h0102, 2'd0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h05060708, 2'b00, 1'b1);
    expectBeat("b2b.w0b1", 1'b1, 16'h0304, 2'd1, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 2'b10, 1'b1);
    expectBeat("b2b.w1b0", 1'b1, 16'h0506, 2'd0, 1'b0, 1'b0);
    tick();
    expectBeat("b2b.w1b1", 1'b1, 16'h0708, 2'd1, 1'b1, 1'b1);
    tick();
    expectBeat("b2b.idle", 1'b0, 16'h0, 2'd0, 1'b0, 1'b1);

    // Reset mid-word
    applyStimulus(1'b1, 32'h11223344, 2'b00, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b1);
    expectBeat("mid.b0", 1'b1, 16'h1122, 2'd0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    checkOutput("mid.rst.valid", 32'(out_valid), 32'd0);
    checkOutput("mid.rst.ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    expectBeat("mid.after", 1'b0, 16'h0, 2'd0, 1'b0, 1'b1);
    checkOutput("mid.after.data", 32'(out_data), 32'd0);
    checkOutput("mid.after.beat", 32'(out_beat), 32'd0);

    // Degenerate OUT_LANES == IN_LANES: single beat equal to the word in both split orders
    d_in_data = 32'hDEADBEEF; d_in_mode = 2'b00; d_in_valid = 1'b1;
    tick();
    d_in_valid = 1'b0;
    #1;
    checkOutput("deg.asc.valid", 32'(d_out_valid), 32'd1);
    checkOutput("deg.asc.data",  32'(d_out_data),  32'hDEADBEEF);
    checkOutput("deg.asc.last",  32'(d_out_last),  32'd1);
    checkOutput("deg.asc.beat",  32'(d_out_beat),  32'd0);
    checkOutput("deg.asc.ready", 32'(d_in_ready),  32'd1);
    tick();
    checkOutput("deg.idle.valid", 32'(d_out_valid), 32'd0);
    d_in_data = 32'hCAFEF00D; d_in_mode = 2'b01; d_in_valid = 1'b1;
    tick();
    d_in_valid = 1'b0;
    #1;
    checkOutput("deg.desc.data", 32'(d_out_data), 32'hCAFEF00D);
    checkOutput("deg.desc.last", 32'(d_out_last), 32'd1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
